// File: rtl/fa_serial_seq.sv
// Bit-serial adder: one behavioural full-adder cell is stepped over WIDTH
// clock edges, LSB first, to produce {Cout, Sum} = A + B + Cin.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for Start; Sum/Cout hold the last result
// RUN     | one operand bit per edge through the full adder
// DONE    | single-cycle Done pulse, result registers just updated

module fa_behave (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain 1-bit full adder.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

module fa_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ps;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH:0]   ps_cat;
    logic [WIDTH-1:0] ps_next;

    fa_behave u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; the concatenate-and-slice form also
    // works for WIDTH == 1 where ps[WIDTH-1:1] would be an empty range.
    always_comb begin
        ps_cat  = {fa_sum, ps};
        ps_next = ps_cat[WIDTH:1];
    end

    // Sequencer: operand shifting, carry chaining and result capture.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        sa    <= A;
                        sb    <= B;
                        c     <= Cin;
                        cnt   <= '0;
                        ps    <= '0;
                        Busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    ps  <= ps_next;
                    c   <= fa_cout;
                    cnt <= cnt + CNT_ONE;
                    if (cnt == LAST_BIT) begin
                        Sum   <= ps_next;
                        Cout  <= fa_cout;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
